pkt_delimit: RTL and testbench
==============================

// Module: pkt_delimit
// PURPOSE
//  Marks packet boundaries on a raw write-strobed byte stream. Tags each beat with SOP/EOP
//  flags and reports packet length, with optional length policing.
//  Sits between the stream source and the framing/PSC logic.
//  Gap-delimited input: a packet is a run of contiguous i_data_wr=1 cycles, min 1 idle cycle between packets.
// PARAMETERS
//  DATA_WIDTH  8     payload bits per beat
//  LEN_WIDTH   12    width of length counter / ov_pkt_len
//  MAX_LEN     1518  max beats per packet (used only with PKT_LEN_CHECK_EN); 1..2**LEN_WIDTH-1
//  MIN_LEN     4     min beats per packet (used only with PKT_LEN_CHECK_EN); 1..MAX_LEN
// PORTS
//  i_clk        in   1             clock, all logic on rising edge
//  i_rst_n      in   1             async active-low reset
//  iv_data      in   DATA_WIDTH    input beat
//  i_data_wr    in   1             input beat valid; high for every beat of a packet
//  ov_data      out  DATA_WIDTH+2  {sop, eop, data}: bit DW+1=SOP, bit DW=EOP
//  o_data_wr    out  1             ov_data valid
//  ov_pkt_len   out  LEN_WIDTH     beats emitted in packet; valid only on EOP beat, else 0
//  o_len_err    out  1             1-cycle pulse on EOP beat of a runt or truncated packet
// BEHAVIOUR
//  Reset: ov_data=0, o_data_wr=0, ov_pkt_len=0, o_len_err=0, cnt=0, hold_vld=0, state=DROP_S.
//  Reset state DROP_S: a packet in flight at reset release is discarded, never emitted.
//  Latency: fixed 1 cycle. Beat N is held one cycle, so EOP is known when wr is sampled low.
//  FSM states:
//   IDLE_S: wr=1 -> capture beat, hold_sop=1, cnt=1, go PKT_S. Outputs idle.
//   PKT_S:  wr=1 -> emit held beat with eop=0, capture new beat, hold_sop=0, cnt+1.
//           wr=0 -> emit held beat with eop=1 and ov_pkt_len=cnt, go IDLE_S.
//   DROP_S: outputs idle, wr ignored; wr=0 -> IDLE_S.
//  Single-beat packet: emitted beat has sop=eop=1, ov_pkt_len=1.
//  Back-to-back packets with no idle cycle: merged into one packet (source contract violation; not detected).
//  Counter saturates at 2**LEN_WIDTH-1 (no wrap).
//  Async reset mid-packet: outputs drop to 0 immediately; no EOP is emitted for the cut packet.
// CONFIGURATION
//  `PKT_LEN_CHECK_EN defined:
//   - Truncation: in PKT_S, if cnt==MAX_LEN and wr=1, the held beat is emitted with eop=1,
//     ov_pkt_len=MAX_LEN and o_len_err=1, and the FSM goes to DROP_S.
//     Remaining beats are dropped until wr=0.
//   - Runt: on an EOP with cnt<MIN_LEN, o_len_err=1 and the beats are still emitted.
//  `PKT_LEN_CHECK_EN undefined:
//   - No truncation, DROP_S is reached only from reset.
//   - o_len_err is tied 0; MAX_LEN/MIN_LEN are unused.
// STRUCTURE
//  pkt_delimit_pkg: state enum (IDLE_S/PKT_S/DROP_S), SOP_BIT/EOP_BIT index functions of DATA_WIDTH.
//  Sub-module pkt_len_chk: counter + saturation + MIN/MAX compare.
//   - Outputs: cnt, at_max, is_runt.
//   - Contains all `PKT_LEN_CHECK_EN-dependent compare logic.
//  Top level: FSM, hold register, output registers.
// TESTING
//  1. Reset release with wr=1 for 3 cycles, then 0 -> no o_data_wr; next packet accepted normally.
//  2. 5-beat packet 0x11..0x15 -> 5 outputs, 1 cycle later.
//     - 0x211 (sop), 0x012..0x014, then 0x115 (eop) with ov_pkt_len=5.
//  3. 1-beat packet 0xA5 -> single output 0x3A5, ov_pkt_len=1; o_len_err=1 iff CHECK_EN and MIN_LEN=4.
//  4. CHECK_EN, MAX_LEN=4, 7-beat packet -> 4 outputs, 4th has eop, ov_pkt_len=4, o_len_err=1.
//     - Beats 5-7 dropped; next packet after the gap is normal.
//  5. Two 3-beat packets separated by 1 idle cycle -> two sop/eop-framed packets, both len=3.
//  6. i_rst_n low on 3rd beat of 6-beat packet -> outputs 0 immediately.
//     - Remainder of packet after release is dropped.
//     - Next packet gives sop and a correct len.

Source files
------------

// File: rtl/pkt_delimit_pkg.sv
// Shared types and bit-position helpers for the pkt_delimit stream delimiter.
package pkt_delimit_pkg;

    typedef enum logic [1:0] {
        IDLE_S = 2'd0,
        PKT_S  = 2'd1,
        DROP_S = 2'd2
    } state_e;

    // Flag positions within the {sop, eop, data} output word.
    function automatic int unsigned sop_bit(input int unsigned data_width);
        return data_width + 1;
    endfunction

    function automatic int unsigned eop_bit(input int unsigned data_width);
        return data_width;
    endfunction

endpackage

// File: rtl/pkt_len_chk.sv
// Packet beat counter with saturation and optional MIN/MAX length compare.
// Compare logic is present only when PKT_LEN_CHECK_EN is defined.
module pkt_len_chk #(
    parameter int unsigned LEN_WIDTH = 12,
    parameter int unsigned MAX_LEN   = 1518,
    parameter int unsigned MIN_LEN   = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 start,
    input  logic                 inc,
    output logic [LEN_WIDTH-1:0] cnt,
    output logic                 at_max,
    output logic                 is_runt
);

    localparam logic [LEN_WIDTH-1:0] CntSat = '1;

    if (MIN_LEN < 1 || MIN_LEN > MAX_LEN || MAX_LEN > (2 ** LEN_WIDTH) - 1) begin : g_param_err
        $error("pkt_len_chk: illegal MIN_LEN/MAX_LEN for LEN_WIDTH");
    end

    logic [LEN_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = LEN_WIDTH'(1);
        end else if (inc && cnt_q != CntSat) begin
            cnt_d = cnt_q + LEN_WIDTH'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

`ifdef PKT_LEN_CHECK_EN
    assign at_max  = (cnt_q == LEN_WIDTH'(MAX_LEN));
    assign is_runt = (cnt_q <  LEN_WIDTH'(MIN_LEN));
`else
    assign at_max  = 1'b0;
    assign is_runt = 1'b0;
`endif

endmodule

// File: rtl/pkt_delimit.sv
// Gap-delimited packet marker: tags beats with SOP/EOP and reports length, 1-cycle latency.
// Optional length policing (truncation at MAX_LEN, runt flag) is enabled by PKT_LEN_CHECK_EN.
module pkt_delimit
    import pkt_delimit_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned LEN_WIDTH  = 12,
    parameter int unsigned MAX_LEN    = 1518,
    parameter int unsigned MIN_LEN    = 4
) (
    input  logic                  i_clk,
    input  logic                  i_rst_n,
    input  logic [DATA_WIDTH-1:0] iv_data,
    input  logic                  i_data_wr,
    output logic [DATA_WIDTH+1:0] ov_data,
    output logic                  o_data_wr,
    output logic [LEN_WIDTH-1:0]  ov_pkt_len,
    output logic                  o_len_err
);

    localparam int unsigned SopIdx = sop_bit(DATA_WIDTH);
    localparam int unsigned EopIdx = eop_bit(DATA_WIDTH);

    state_e state_q, state_d;

    logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
    logic                  hold_sop_q, hold_sop_d;
    logic                  hold_vld_q, hold_vld_d;

    logic [DATA_WIDTH+1:0] out_data_q, out_data_d;
    logic                  out_wr_q, out_wr_d;
    logic [LEN_WIDTH-1:0]  out_len_q, out_len_d;
    logic                  out_err_q, out_err_d;

    logic                 cnt_start, cnt_inc;
    logic [LEN_WIDTH-1:0] cnt;
    logic                 at_max, is_runt;

    pkt_len_chk #(
        .LEN_WIDTH (LEN_WIDTH),
        .MAX_LEN   (MAX_LEN),
        .MIN_LEN   (MIN_LEN)
    ) u_len_chk (
        .clk     (i_clk),
        .rst_n   (i_rst_n),
        .start   (cnt_start),
        .inc     (cnt_inc),
        .cnt     (cnt),
        .at_max  (at_max),
        .is_runt (is_runt)
    );

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= DROP_S;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE_S: if (i_data_wr) state_d = PKT_S;
            PKT_S: begin
                if (!i_data_wr) state_d = IDLE_S;
                else if (at_max) state_d = DROP_S;
            end
            DROP_S: if (!i_data_wr) state_d = IDLE_S;
            default: state_d = DROP_S;
        endcase
    end

    // The held beat is emitted the cycle after capture; a low strobe or a full count closes it.
    always_comb begin
        hold_data_d = hold_data_q;
        hold_sop_d  = hold_sop_q;
        hold_vld_d  = hold_vld_q;
        out_data_d  = '0;
        out_wr_d    = 1'b0;
        out_len_d   = '0;
        out_err_d   = 1'b0;
        cnt_start   = 1'b0;
        cnt_inc     = 1'b0;
        unique case (state_q)
            IDLE_S: begin
                if (i_data_wr) begin
                    hold_data_d = iv_data;
                    hold_sop_d  = 1'b1;
                    hold_vld_d  = 1'b1;
                    cnt_start   = 1'b1;
                end
            end
            PKT_S: begin
                out_wr_d                     = hold_vld_q;
                out_data_d[DATA_WIDTH-1:0]   = hold_data_q;
                out_data_d[SopIdx]           = hold_sop_q;
                if (i_data_wr && !at_max) begin
                    hold_data_d = iv_data;
                    hold_sop_d  = 1'b0;
                    cnt_inc     = 1'b1;
                end else begin
                    out_data_d[EopIdx] = 1'b1;
                    out_len_d          = cnt;
                    out_err_d          = (i_data_wr && at_max) || is_runt;
                    hold_vld_d         = 1'b0;
                end
            end
            DROP_S: ;
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            hold_data_q <= '0;
            hold_sop_q  <= 1'b0;
            hold_vld_q  <= 1'b0;
            out_data_q  <= '0;
            out_wr_q    <= 1'b0;
            out_len_q   <= '0;
            out_err_q   <= 1'b0;
        end else begin
            hold_data_q <= hold_data_d;
            hold_sop_q  <= hold_sop_d;
            hold_vld_q  <= hold_vld_d;
            out_data_q  <= out_data_d;
            out_wr_q    <= out_wr_d;
            out_len_q   <= out_len_d;
            out_err_q   <= out_err_d;
        end
    end

    assign ov_data    = out_data_q;
    assign o_data_wr  = out_wr_q;
    assign ov_pkt_len = out_len_q;
    assign o_len_err  = out_err_q;

endmodule

// File: tb/tb_pkt_delimit.sv
// Directed self-checking bench for pkt_delimit (DATA_WIDTH=8, MAX_LEN=6, MIN_LEN=4).
// Expectations follow PKT_LEN_CHECK_EN when it is defined for the build.
module tb_pkt_delimit;

`ifdef PKT_LEN_CHECK_EN
    localparam logic ChkEn = 1'b1;
`else
    localparam logic ChkEn = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic [7:0]  data_in;
    logic        wr_in;
    logic [9:0]  data_out;
    logic        wr_out;
    logic [11:0] len_out;
    logic        err_out;

    int checks;
    int failures;

    pkt_delimit #(
        .DATA_WIDTH (8),
        .LEN_WIDTH  (12),
        .MAX_LEN    (6),
        .MIN_LEN    (4)
    ) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .iv_data    (data_in),
        .i_data_wr  (wr_in),
        .ov_data    (data_out),
        .o_data_wr  (wr_out),
        .ov_pkt_len (len_out),
        .o_len_err  (err_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            failures++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_out(input string tag, input logic ewr, input logic [9:0] edata,
                           input logic [11:0] elen, input logic eerr);
        chk({tag, ".wr"},   32'(wr_out),   32'(ewr));
        chk({tag, ".data"}, 32'(data_out), 32'(edata));
        chk({tag, ".len"},  32'(len_out),  32'(elen));
        chk({tag, ".err"},  32'(err_out),  32'(eerr));
    endtask

    // Drive one input cycle, then check the outputs registered at the following edge.
    task automatic step(input logic wr, input logic [7:0] d, input string tag, input logic ewr,
                        input logic [9:0] edata, input logic [11:0] elen, input logic eerr);
        @(negedge clk);
        wr_in   = wr;
        data_in = d;
        @(posedge clk);
        #1;
        chk_out(tag, ewr, edata, elen, eerr);
    endtask

    task automatic idle(input logic wr, input logic [7:0] d, input string tag);
        step(wr, d, tag, 1'b0, 10'h000, 12'd0, 1'b0);
    endtask

    initial begin
        checks   = 0;
        failures = 0;
        rst_n    = 1'b0;
        wr_in    = 1'b1;
        data_in  = 8'hEE;

        // 1: packet in flight at reset release is discarded
        #1;
        chk_out("reset", 1'b0, 10'h000, 12'd0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1, 8'hEF, "drop1");
        idle(1'b1, 8'hF0, "drop2");
        idle(1'b0, 8'h00, "drop_end");

        // 2: 5-beat packet
        idle(1'b1, 8'h11, "p5.b1");
        step(1'b1, 8'h12, "p5.o1", 1'b1, 10'h211, 12'd0, 1'b0);
        step(1'b1, 8'h13, "p5.o2", 1'b1, 10'h012, 12'd0, 1'b0);
        step(1'b1, 8'h14, "p5.o3", 1'b1, 10'h013, 12'd0, 1'b0);
        step(1'b1, 8'h15, "p5.o4", 1'b1, 10'h014, 12'd0, 1'b0);
        step(1'b0, 8'h00, "p5.o5", 1'b1, 10'h115, 12'd5, 1'b0);
        idle(1'b0, 8'h00, "p5.gap");

        // 3: single-beat packet, a runt when checking is enabled
        idle(1'b1, 8'hA5, "p1.b1");
        step(1'b0, 8'h00, "p1.o1", 1'b1, 10'h3A5, 12'd1, ChkEn);
        idle(1'b0, 8'h00, "p1.gap");

        // 4: 9-beat packet against MAX_LEN=6
        idle(1'b1, 8'h31, "p9.b1");
        step(1'b1, 8'h32, "p9.o1", 1'b1, 10'h231, 12'd0, 1'b0);
        step(1'b1, 8'h33, "p9.o2", 1'b1, 10'h032, 12'd0, 1'b0);
        step(1'b1, 8'h34, "p9.o3", 1'b1, 10'h033, 12'd0, 1'b0);
        step(1'b1, 8'h35, "p9.o4", 1'b1, 10'h034, 12'd0, 1'b0);
        step(1'b1, 8'h36, "p9.o5", 1'b1, 10'h035, 12'd0, 1'b0);
`ifdef PKT_LEN_CHECK_EN
        step(1'b1, 8'h37, "p9.trunc", 1'b1, 10'h136, 12'd6, 1'b1);
        idle(1'b1, 8'h38, "p9.drop8");
        idle(1'b1, 8'h39, "p9.drop9");
        idle(1'b0, 8'h00, "p9.gap");
`else
        step(1'b1, 8'h37, "p9.o6", 1'b1, 10'h036, 12'd0, 1'b0);
        step(1'b1, 8'h38, "p9.o7", 1'b1, 10'h037, 12'd0, 1'b0);
        step(1'b1, 8'h39, "p9.o8", 1'b1, 10'h038, 12'd0, 1'b0);
        step(1'b0, 8'h00, "p9.o9", 1'b1, 10'h139, 12'd9, 1'b0);
`endif
        idle(1'b0, 8'h00, "p9.gap2");

        // 5: two 3-beat packets separated by one idle cycle
        idle(1'b1, 8'h41, "pa.b1");
        step(1'b1, 8'h42, "pa.o1", 1'b1, 10'h241, 12'd0, 1'b0);
        step(1'b1, 8'h43, "pa.o2", 1'b1, 10'h042, 12'd0, 1'b0);
        step(1'b0, 8'h00, "pa.o3", 1'b1, 10'h143, 12'd3, ChkEn);
        idle(1'b1, 8'h51, "pb.b1");
        step(1'b1, 8'h52, "pb.o1", 1'b1, 10'h251, 12'd0, 1'b0);
        step(1'b1, 8'h53, "pb.o2", 1'b1, 10'h052, 12'd0, 1'b0);
        step(1'b0, 8'h00, "pb.o3", 1'b1, 10'h153, 12'd3, ChkEn);
        idle(1'b0, 8'h00, "pb.gap");

        // 6: asynchronous reset on the 3rd beat of a 6-beat packet
        idle(1'b1, 8'h61, "pr.b1");
        step(1'b1, 8'h62, "pr.o1", 1'b1, 10'h261, 12'd0, 1'b0);
        @(negedge clk);
        data_in = 8'h63;
        rst_n   = 1'b0;
        #1;
        chk_out("pr.async", 1'b0, 10'h000, 12'd0, 1'b0);
        @(negedge clk);
        rst_n = 1'b1;
        idle(1'b1, 8'h64, "pr.drop4");
        idle(1'b1, 8'h65, "pr.drop5");
        idle(1'b1, 8'h66, "pr.drop6");
        idle(1'b0, 8'h00, "pr.gap");
        idle(1'b1, 8'h71, "pn.b1");
        step(1'b1, 8'h72, "pn.o1", 1'b1, 10'h271, 12'd0, 1'b0);
        step(1'b1, 8'h73, "pn.o2", 1'b1, 10'h072, 12'd0, 1'b0);
        step(1'b1, 8'h74, "pn.o3", 1'b1, 10'h073, 12'd0, 1'b0);
        step(1'b0, 8'h00, "pn.o4", 1'b1, 10'h174, 12'd4, 1'b0);
        idle(1'b0, 8'h00, "pn.gap");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
